// File: rtl/vga_sync_ctrl_signal_gen.sv
// VGA raster timing generator: position counters plus registered sync,
// data-enable and line/frame start pulses, all aligned to the sx/sy they describe.
module vga_sync_ctrl_signal_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [15:0] sx,
  output logic [15:0] sy,
  output logic        hsync,
  output logic        vsync,
  output logic        data_enable,
  output logic        frame_pulse,
  output logic        line_pulse
);

  localparam logic [15:0] H_TOTAL  = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [15:0] V_TOTAL  = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [15:0] H_VIS    = 16'(H_ACTIVE);
  localparam logic [15:0] V_VIS    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

  logic [15:0] next_x;
  logic [15:0] next_y;

  // Outputs are decoded from the next position so they land in the same
  // register stage as the counters themselves.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    next_x = sx + 16'd1;
    next_y = sy;
    if (sx == H_TOTAL - 16'd1) begin
      next_x = '0;
      next_y = (sy == V_TOTAL - 16'd1) ? '0 : sy + 16'd1;
    end
  end

  // Reset parks the raster at its last position so the first active edge
  // lands on (0,0) and flags the first frame.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      sx          <= H_TOTAL - 16'd1;
      sy          <= V_TOTAL - 16'd1;
      hsync       <= ~H_SYNC_POL;
      vsync       <= ~V_SYNC_POL;
      data_enable <= 1'b0;
      frame_pulse <= 1'b0;
      line_pulse  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
      sx          <= next_x;
      sy          <= next_y;
      hsync       <= (next_x >= HS_START && next_x < HS_END) ? H_SYNC_POL : ~H_SYNC_POL;
      vsync       <= (next_y >= VS_START && next_y < VS_END) ? V_SYNC_POL : ~V_SYNC_POL;
      data_enable <= (next_x < H_VIS) && (next_y < V_VIS);
      frame_pulse <= (next_x == 16'd0) && (next_y == 16'd0);
      line_pulse  <= (next_x == 16'd0);
    end
  end

endmodule

// File: tb/tb_vga_sync_ctrl_signal_gen.sv
// Bench for the VGA timing generator: a full-size instance for reset and line
// timing, and a scaled instance (inverted polarities) for whole-frame behaviour.
module tb_vga_sync_ctrl_signal_gen;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #20 clk = ~clk;

  logic [15:0] b_sx, b_sy, s_sx, s_sy;
  logic b_hs, b_vs, b_de, b_fp, b_lp;
  logic s_hs, s_vs, s_de, s_fp, s_lp;

  vga_sync_ctrl_signal_gen u_big (
    .clk(clk), .resetn(resetn), .sx(b_sx), .sy(b_sy), .hsync(b_hs), .vsync(b_vs),
    .data_enable(b_de), .frame_pulse(b_fp), .line_pulse(b_lp));

  vga_sync_ctrl_signal_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(3), .V_SYNC(2), .V_BP(5),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) u_small (
    .clk(clk), .resetn(resetn), .sx(s_sx), .sy(s_sy), .hsync(s_hs), .vsync(s_vs),
    .data_enable(s_de), .frame_pulse(s_fp), .line_pulse(s_lp));

  logic [36:0] obs_big, obs_small;
  assign obs_big   = {b_sx, b_sy, b_hs, b_vs, b_de, b_fp, b_lp};
  assign obs_small = {s_sx, s_sy, s_hs, s_vs, s_de, s_fp, s_lp};

  int errors = 0;
  int checks = 0;
  longint cyc = 0;  // rising edges seen since reset was released

  // Reference: position follows from elapsed clocks; outputs follow from position.
  function automatic logic [36:0] model(input int ha, hf, hs, hb, va, vf, vs, vb,
                                        input bit hpol, vpol, input longint c);
    int ht, vt, x, y;
    longint p;
    bit h, v, de, fp, lp;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    if (c == 0) begin
      x = ht - 1;
      y = vt - 1;
    end else begin
      p = c - 1;
      x = int'(p % ht);
      y = int'((p / ht) % vt);
    end
    h  = (x >= ha + hf && x < ha + hf + hs) ? hpol : ~hpol;
    v  = (y >= va + vf && y < va + vf + vs) ? vpol : ~vpol;
    de = (x < ha) && (y < va);
    lp = (c != 0) && (x == 0);
    fp = lp && (y == 0);
    return {x[15:0], y[15:0], h, v, de, fp, lp};
  endfunction

  function automatic logic [36:0] exp_big();
    return model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, cyc);
  endfunction

  function automatic logic [36:0] exp_small();
    return model(64, 4, 8, 4, 48, 3, 2, 5, 1'b1, 1'b1, cyc);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!resetn) cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [36:0] e;
    resetn = 1'b1;
    cyc = 0;
    repeat ($urandom_range(2, 6)) tick();
    checks++;
    if (obs_big !== {16'd799, 16'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_big_state: got %h expected %h", obs_big,
               {16'd799, 16'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    end
    e = exp_small();
    checks++;
    if (obs_small !== e) begin
      errors++;
      $display("FAIL reset_small_state: got %h expected %h", obs_small, e);
    end
    resetn = 1'b0;
    tick();
    checks++;
    if (obs_big !== {16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL release_big_first: got %h expected %h", obs_big,
               {16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
    end
    e = exp_small();
    checks++;
    if (obs_small !== e) begin
      errors++;
      $display("FAIL release_small_first: got %h expected %h", obs_small, e);
    end
  endtask

  task automatic test_hline();
    logic [36:0] e;
    int de_cnt = 0, hs_cnt = 0, lp_cnt = 0, hs_first = -1, hs_last = -1, bad = 0;
    for (int i = 0; i < 1600; i++) begin
      tick();
      e = exp_big();
      if (obs_big !== e) begin
        bad++;
        $display("FAIL hline_big cyc=%0d: got %h expected %h", cyc, obs_big, e);
      end
      if (b_lp) lp_cnt++;
      if (b_sy == 16'd1) begin
        if (b_de) de_cnt++;
        if (!b_hs) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(b_sx);
          hs_last = int'(b_sx);
        end
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hline_cycles: got %0d bad cycles expected 0", bad);
    end
    checks++;
    if (de_cnt != 640) begin
      errors++;
      $display("FAIL hline_de_width: got %0d expected 640", de_cnt);
    end
    checks++;
    if (hs_cnt != 96 || hs_first != 656 || hs_last != 751) begin
      errors++;
      $display("FAIL hline_hsync: got %0d clocks %0d..%0d expected 96 clocks 656..751",
               hs_cnt, hs_first, hs_last);
    end
    checks++;
    if (lp_cnt != 2) begin
      errors++;
      $display("FAIL hline_line_pulses: got %0d expected 2", lp_cnt);
    end
  endtask

  task automatic test_frames();
    logic [36:0] e;
    longint fp_at[$];
    int lp_cnt = 0, vs_cnt = 0, de_blank = 0, bad = 0, wraps = 0;
    logic prev_corner = 1'b0;
    for (int i = 0; i < 3 * 4640 + 20 && fp_at.size() < 3; i++) begin
      tick();
      e = exp_small();
      if (obs_small !== e) begin
        bad++;
        $display("FAIL frame_small cyc=%0d: got %h expected %h", cyc, obs_small, e);
      end
      if (prev_corner) begin
        wraps++;
        checks++;
        if (obs_small !== {16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}) begin
          errors++;
          $display("FAIL wrap_corner: got %h expected %h", obs_small,
                   {16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
        end
      end
      prev_corner = (s_sx == 16'd79) && (s_sy == 16'd57);
      if (s_de && s_sy >= 16'd48) de_blank++;
      if (fp_at.size() == 1) begin
        if (s_lp) lp_cnt++;
        if (s_vs) vs_cnt++;
      end
      if (s_fp) fp_at.push_back(cyc);
    end
    checks++;
    if (fp_at.size() != 3) begin
      errors++;
      $display("FAIL frame_pulse_count: got %0d expected 3", fp_at.size());
    end else begin
      checks++;
      if (fp_at[1] - fp_at[0] != 4640 || fp_at[2] - fp_at[1] != 4640) begin
        errors++;
        $display("FAIL frame_period: got %0d,%0d expected 4640",
                 fp_at[1] - fp_at[0], fp_at[2] - fp_at[1]);
      end
      checks++;
      if (lp_cnt != 58) begin
        errors++;
        $display("FAIL lines_per_frame: got %0d expected 58", lp_cnt);
      end
      checks++;
      if (vs_cnt != 160) begin
        errors++;
        $display("FAIL vsync_width: got %0d expected 160", vs_cnt);
      end
    end
    checks++;
    if (bad != 0 || de_blank != 0 || wraps == 0) begin
      errors++;
      $display("FAIL frame_cycles: got bad=%0d de_blank=%0d wraps=%0d expected 0,0,>0",
               bad, de_blank, wraps);
    end
  endtask

  task automatic test_mid_reset();
    logic [36:0] e;
    int tx, ty, bad = 0;
    bit found = 1'b0;
    tx = $urandom_range(1, 79);
    ty = $urandom_range(1, 57);
    for (int i = 0; i < 4700 && !found; i++) begin
      tick();
      e = exp_small();
      if (e[36:21] == 16'(tx) && e[20:5] == 16'(ty)) found = 1'b1;
    end
    checks++;
    if (!found || obs_small !== e) begin
      errors++;
      $display("FAIL mid_reset_reach: got %h expected %h found=%0d", obs_small, e, found);
    end
    #($urandom_range(3, 15));
    resetn = 1'b1;
    cyc = 0;
    #1;
    checks++;
    if (obs_big !== exp_big() || obs_small !== exp_small()) begin
      errors++;
      $display("FAIL mid_reset_async: got %h/%h expected %h/%h",
               obs_big, obs_small, exp_big(), exp_small());
    end
    @(negedge clk);
    repeat ($urandom_range(1, 4)) tick();
    checks++;
    if (obs_big !== exp_big() || obs_small !== exp_small()) begin
      errors++;
      $display("FAIL mid_reset_hold: got %h/%h expected %h/%h",
               obs_big, obs_small, exp_big(), exp_small());
    end
    resetn = 1'b0;
    tick();
    checks++;
    if (obs_big !== {16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1} || obs_small !== exp_small()) begin
      errors++;
      $display("FAIL mid_reset_restart: got %h/%h expected %h/%h", obs_big, obs_small,
               {16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}, exp_small());
    end
    for (int i = 0; i < 300; i++) begin
      tick();
      if (obs_big !== exp_big() || obs_small !== exp_small()) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_reset_resume: got %0d bad cycles expected 0", bad);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_hline();
    test_frames();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_ctrl_signal_gen.md
Name: vga_sync_ctrl_signal_gen

Overview:
Generates VGA 640x480@60 Hz raster timing from a 25 MHz pixel clock. It keeps horizontal and vertical position counters and decodes hsync, vsync, active-video enable, and per-line and per-frame start pulses from them. It sits between the pixel clock domain and the pixel/framebuffer logic and the VGA output pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_POL, 0, hsync active level (0 = active-low)
V_SYNC_POL, 0, vsync active level (0 = active-low)

Ports:
clk  input  1  pixel clock, 25 MHz nominal; all logic on rising edge
resetn  input  1  asynchronous reset, active-high (asserted when 1)
sx  output  16  current horizontal position, 0..H_TOTAL-1
sy  output  16  current vertical position, 0..V_TOTAL-1
hsync  output  1  horizontal sync
vsync  output  1  vertical sync
data_enable  output  1  high while the position is in the visible area
frame_pulse  output  1  one-cycle pulse at the first pixel of each frame
line_pulse  output  1  one-cycle pulse at the first pixel of each line

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). All arithmetic is unsigned 16-bit.
- sx increments by 1 every clock. When sx = H_TOTAL-1, it wraps to 0 and sy increments. When sy = V_TOTAL-1 and sx wraps, sy wraps to 0.
- All outputs are registered. Each is computed from the next counter value, so every output is cycle-aligned with the sx/sy it describes. There are no combinational paths from inputs to outputs.
- hsync is at H_SYNC_POL when H_ACTIVE+H_FP <= sx < H_ACTIVE+H_FP+H_SYNC (656..751); otherwise it is at the inverse level.
- vsync is at V_SYNC_POL when V_ACTIVE+V_FP <= sy < V_ACTIVE+V_FP+V_SYNC (490..491), for the full width of those lines; otherwise it is at the inverse level.
- data_enable = (sx < H_ACTIVE) AND (sy < V_ACTIVE).
- line_pulse = (sx == 0). It fires on every line, including blanking lines, giving 525 pulses per frame.
- frame_pulse = (sx == 0) AND (sy == 0). It is a single cycle, once per frame. Coincident with it, line_pulse and data_enable are also high.
- Reset state, while resetn = 1:
  - sx = H_TOTAL-1 (799), sy = V_TOTAL-1 (524)
  - hsync and vsync inactive (1 with default polarity)
  - data_enable = 0, frame_pulse = 0, line_pulse = 0
  - These values are consistent with position (799,524).
- First rising edge after reset deasserts: sx=0, sy=0, frame_pulse=1, line_pulse=1, data_enable=1. The first frame is therefore flagged.
- Reset asserted mid-frame immediately forces the reset state, with no pending pulse.
- Line period is 800 clocks; frame period is 420000 clocks, or 16.8 ms at 25 MHz (59.52 Hz).

Test Plan:
- Reset: hold resetn=1 -> sx=799, sy=524, hsync=vsync=1, data_enable=frame_pulse=line_pulse=0. Then release -> next edge gives sx=0, sy=0, frame_pulse=line_pulse=data_enable=1.
- Horizontal timing over one line:
  - data_enable high for sx 0..639 (640 clocks)
  - hsync low exactly for sx 656..751 (96 clocks)
  - line_pulse every 800 clocks
  - sx wraps 799->0 with sy+1
- Vertical timing:
  - vsync low exactly during sy 490..491 (1600 clocks)
  - data_enable never high for sy >= 480
  - 525 line_pulses between consecutive frame_pulses
- Frame cadence: frame_pulse single-cycle and 420000 clocks apart. In a 1 s run at 40 ns clock, count 60 frame_pulse rising edges.
- Mid-operation reset: assert resetn at sx=300, sy=200 -> outputs go to the reset state asynchronously. After release, the sequence restarts at (0,0) with frame_pulse.
- Wrap corner: at sx=799, sy=524 -> next clock gives sx=0, sy=0, frame_pulse=1, vsync=1, hsync=1.
